// File: rtl/viterbi_pkg.sv
// Shared K=3 Viterbi definitions (BMC array, ACS, traceback).
//   NUM_STATES/BM_W/NUM_BR : trellis sizing
//   bm_t / pm_t            : branch-metric and default-width path-metric types
//   pred0/pred1            : even/odd predecessor of next state s' (s'={u,s[1]})
//   br_idx                 : branch index {p,u} into the BMC metric vector
package viterbi_pkg;
    localparam int NUM_STATES = 4;
    localparam int BM_W       = 2;
    localparam int NUM_BR     = 8;
    localparam int PM_W_DEF   = 8;

    typedef logic [BM_W-1:0]     bm_t;
    typedef logic [PM_W_DEF-1:0] pm_t;
    typedef logic [1:0]          state_t;

    function automatic state_t pred0(input state_t s);
        return {s[0], 1'b0};
    endfunction

    function automatic state_t pred1(input state_t s);
        return {s[0], 1'b1};
    endfunction

    function automatic logic [2:0] br_idx(input state_t p, input logic u);
        return {p, u};
    endfunction
endpackage

// File: rtl/pm_acs_unit_if.sv
// Handshake bundle between BMC array -> ACS -> traceback.
//   in_*  : branch-metric set from BMC (valid/ready, frame-first flag, 8x2b metrics)
//   out_* : decision word to traceback (valid/ready, dec bits, best state, min metric)
// master = surrounding logic / bench, slave = pm_acs_unit.
interface pm_acs_unit_if #(parameter int PM_W = 8);
    logic            in_valid_i;
    logic            in_ready_o;
    logic            in_first_i;
    logic [15:0]     bm_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [3:0]      dec_o;
    logic [1:0]      best_o;
    logic [PM_W-1:0] min_pm_o;

    modport master (
        output in_valid_i, in_first_i, bm_i, out_ready_i,
        input  in_ready_o, out_valid_o, dec_o, best_o, min_pm_o
    );
    modport slave (
        input  in_valid_i, in_first_i, bm_i, out_ready_i,
        output in_ready_o, out_valid_o, dec_o, best_o, min_pm_o
    );
endinterface

// File: rtl/pm_acs_unit_acs_cell.sv
// One add-compare-select cell for a single next state.
//   pm0/pm1 : path metrics of even/odd predecessor
//   bm0/bm1 : branch metrics on the two incoming branches
//   pm_sel  : surviving metric; dec : 1 when the odd predecessor wins
// Adds saturate at all-ones; a tie keeps the even predecessor.
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  bm_t             bm0,
    input  bm_t             bm1,
    output logic [PM_W-1:0] pm_sel,
    output logic            dec
);
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input bm_t b);
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W+1-BM_W){1'b0}}, b};
        return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
    endfunction

    logic [PM_W-1:0] c0, c1;

    assign c0     = sat_add(pm0, bm0);
    assign c1     = sat_add(pm1, bm1);
    assign dec    = (c1 < c0);
    assign pm_sel = dec ? c1 : c0;
endmodule

// File: rtl/pm_acs_unit.sv
// Path-metric / ACS stage of the K=3 Viterbi decoder.
//   clk, rst : clock, async active-high reset
//   bus      : pm_acs_unit_if.slave (BMC input handshake, traceback output handshake)
// Per accepted metric set: 4 ACS cells, min/best search, optional normalisation,
// 1-deep registered output. Optional feature macro: PM_ACS_NORM_EN (subtract the
// new minimum from all stored metrics; min_pm_o still reports the raw minimum).
module pm_acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W     = 8,
    parameter int INIT_PEN = 16
) (
    input  logic           clk,
    input  logic           rst,
    pm_acs_unit_if.slave   bus
);
    localparam logic [NUM_STATES-1:0][PM_W-1:0] PM_INIT =
        {{(NUM_STATES-1){PM_W'(INIT_PEN)}}, {PM_W{1'b0}}};

    logic [NUM_STATES-1:0][PM_W-1:0] pm_q, pm_src, pm_new, pm_nxt;
    logic [NUM_STATES-1:0]           dec_new, dec_q;
    logic [NUM_BR-1:0][BM_W-1:0]     bm;
    logic [PM_W-1:0]                 min_pm, min_q;
    state_t                          best, best_q;
    logic                            out_valid_q, accept;

    assign bm              = bus.bm_i;
    assign bus.in_ready_o  = !out_valid_q | bus.out_ready_i;
    assign accept          = bus.in_valid_i & bus.in_ready_o;
    // frame start restarts from the init vector instead of the stored metrics
    assign pm_src          = bus.in_first_i ? PM_INIT : pm_q;

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        localparam state_t P0  = pred0(state_t'(s));
        localparam state_t P1  = pred1(state_t'(s));
        localparam logic   U   = 1'((s >> 1) & 1);
        localparam int     BI0 = int'(br_idx(P0, U));
        localparam int     BI1 = int'(br_idx(P1, U));

        acs_cell #(.PM_W(PM_W)) u_acs (
            .pm0    (pm_src[P0]),
            .pm1    (pm_src[P1]),
            .bm0    (bm[BI0]),
            .bm1    (bm[BI1]),
            .pm_sel (pm_new[s]),
            .dec    (dec_new[s])
        );
    end

    // strict < keeps the lowest index on ties
    always_comb begin
        min_pm = pm_new[0];
        best   = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_new[i] < min_pm) begin
                min_pm = pm_new[i];
                best   = state_t'(i);
            end
        end
    end

`ifdef PM_ACS_NORM_EN
    always_comb begin
        for (int i = 0; i < NUM_STATES; i++) pm_nxt[i] = pm_new[i] - min_pm;
    end
`else
    assign pm_nxt = pm_new;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm_q        <= PM_INIT;
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            best_q      <= '0;
            min_q       <= '0;
        end else if (accept) begin
            pm_q        <= pm_nxt;
            out_valid_q <= 1'b1;
            dec_q       <= dec_new;
            best_q      <= best;
            min_q       <= min_pm;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.dec_o       = dec_q;
    assign bus.best_o      = best_q;
    assign bus.min_pm_o    = min_q;
endmodule

// File: tb/tb_pm_acs_unit.sv
// Bench for pm_acs_unit: scoreboard queue fed on accept, drained on output pop,
// plus directed checks for reset, tie-break, backpressure, saturation and mid-frame reset.
module tb_pm_acs_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pm_acs_unit_if #(.PM_W(8)) bus ();

    pm_acs_unit #(.PM_W(8), .INIT_PEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] dec;
        logic [1:0] best;
        logic [7:0] mn;
    } exp_t;

    exp_t q[$];
    int   mpm[4];
    int   n_chk = 0, n_pass = 0, n_push = 0, n_pop = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        mpm[0] = 0; mpm[1] = 16; mpm[2] = 16; mpm[3] = 16;
    endfunction

    // Reference ACS step straight from the trellis definition.
    function automatic exp_t model_step(input logic first, input logic [15:0] bmv);
        exp_t e;
        int src[4], nw[4], p0, p1, u, c0, c1, mn, bst;
        for (int i = 0; i < 4; i++) src[i] = first ? ((i == 0) ? 0 : 16) : mpm[i];
        e.dec = '0;
        for (int s = 0; s < 4; s++) begin
            u  = s / 2;
            p0 = (s % 2) * 2;
            p1 = p0 + 1;
            c0 = src[p0] + int'((bmv >> (2 * (p0 * 2 + u))) & 16'd3);
            c1 = src[p1] + int'((bmv >> (2 * (p1 * 2 + u))) & 16'd3);
            if (c0 > 255) c0 = 255;
            if (c1 > 255) c1 = 255;
            nw[s]    = (c1 < c0) ? c1 : c0;
            e.dec[s] = (c1 < c0);
        end
        mn = nw[0]; bst = 0;
        for (int s = 1; s < 4; s++) if (nw[s] < mn) begin mn = nw[s]; bst = s; end
        e.best = 2'(bst);
        e.mn   = 8'(mn);
`ifdef PM_ACS_NORM_EN
        for (int s = 0; s < 4; s++) mpm[s] = nw[s] - mn;
`else
        for (int s = 0; s < 4; s++) mpm[s] = nw[s];
`endif
        return e;
    endfunction

    // Monitor: inputs change only just after posedge, so negedge sampling sees
    // exactly what the DUT will act on at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            model_reset();
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                n_pop++;
                if (q.size() == 0) chk("q_underflow", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("dec",  32'(bus.dec_o),    32'(e.dec));
                    chk("best", 32'(bus.best_o),   32'(e.best));
                    chk("min",  32'(bus.min_pm_o), 32'(e.mn));
                end
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                n_push++;
                q.push_back(model_step(bus.in_first_i, bus.bm_i));
            end
        end
    end

    task automatic send(input logic first, input logic [15:0] bmv);
        int  n;
        logic acc;
        n = 0; acc = 1'b0;
        bus.in_valid_i = 1'b1; bus.in_first_i = first; bus.bm_i = bmv;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        bus.in_valid_i = 1'b0; bus.in_first_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  d0;
        logic [1:0]  b0;
        logic [31:0] p0;
        bus.in_valid_i = 0; bus.in_first_i = 0; bus.bm_i = '0; bus.out_ready_i = 1;
        model_reset();
        idle(3);
        // 1. reset state
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
        chk("rst_dec",       32'(bus.dec_o),       32'd0);
        chk("rst_pm",        32'(dut.pm_q),        32'h10101000);
        rst = 0;
        idle(2);
        chk("idle_out_valid", 32'(bus.out_valid_o), 32'd0);

        // 2. first symbol, zero metrics
        send(1'b1, 16'h0000);
        chk("f_out_valid", 32'(bus.out_valid_o), 32'd1);
        chk("f_dec",       32'(bus.dec_o),       32'd0);
        chk("f_pm",        32'(dut.pm_q),        32'h10001000);
        idle(2);

        // 3. tie-break on state 1 (preds 2,3 both 16): equal -> 0, c1 lower -> 1
        send(1'b1, 16'h0000);
        chk("tie_eq", 32'(bus.dec_o[1]), 32'd0);
        send(1'b1, 16'h0100);
        chk("tie_lt", 32'(bus.dec_o[1]), 32'd1);
        idle(2);

        // 4. backpressure
        bus.out_ready_i = 0;
        send(1'b0, 16'h1234);
        d0 = bus.dec_o; b0 = bus.best_o; p0 = dut.pm_q;
        bus.in_valid_i = 1; bus.bm_i = 16'hC3A5;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
            chk("bp_dec",      32'(bus.dec_o),      32'(d0));
            chk("bp_best",     32'(bus.best_o),     32'(b0));
            chk("bp_pm",       dut.pm_q,            p0);
        end
        @(posedge clk); #1;
        bus.out_ready_i = 1;
        send(1'b0, 16'hC3A5);
        send(1'b0, 16'h5A0F);
        send(1'b0, 16'hFF00);
        send(1'b0, 16'h00FF);
        idle(3);
        chk("bp_pushpop", 32'(n_pop), 32'(n_push));

        // 5. all-3 metrics for 100 symbols
        for (int i = 0; i < 100; i++) send(i == 0, 16'hFFFF);
        idle(2);
`ifdef PM_ACS_NORM_EN
        chk("norm_pm", dut.pm_q, 32'h00000000);
`else
        chk("sat_pm", dut.pm_q, 32'hFFFFFFFF);
`endif

        // 6. reset mid-frame with a word pending
        bus.out_ready_i = 0;
        send(1'b0, 16'h4E1B);
        chk("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
        @(negedge clk); #1;
        rst = 1; #1;
        chk("mrst_valid",    32'(bus.out_valid_o), 32'd0);
        chk("mrst_dec",      32'(bus.dec_o),       32'd0);
        chk("mrst_best",     32'(bus.best_o),      32'd0);
        chk("mrst_min",      32'(bus.min_pm_o),    32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready_o),  32'd1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        bus.out_ready_i = 1;
        send(1'b1, 16'h0000);
        chk("r_out_valid", 32'(bus.out_valid_o), 32'd1);
        chk("r_dec",       32'(bus.dec_o),       32'd0);
        chk("r_pm",        32'(dut.pm_q),        32'h10001000);
        idle(3);
        chk("q_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
